// File: rtl/vboard_refresh_ctrl.sv
// Board panel refresh sequencer: staged output commit, bridge req/ack handshake, input capture.
// Optional per-bit input debounce is enabled by defining VBOARD_DEBOUNCE_EN.
module vboard_refresh_ctrl #(
    parameter int IN_W        = 43,
    parameter int OUT_W       = 82,
    parameter int REFRESH_DIV = 1000,
    parameter int ACK_TMO     = 255,
    parameter int DEB_CNT     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_idx,
    input  logic [31:0]      wr_data,
    input  logic             force_refresh,
    output logic [OUT_W-1:0] out_vec,
    output logic             refresh_req,
    input  logic             refresh_ack,
    input  logic [IN_W-1:0]  in_vec_raw,
    output logic [IN_W-1:0]  in_vec,
    output logic [IN_W-1:0]  in_chg_mask,
    output logic             in_chg_irq,
    output logic             busy,
    output logic             tmo_err,
    input  logic             err_clr
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int AW = $clog2(ACK_TMO + 1);

    typedef enum logic [1:0] {IDLE, REQ, CAP, DROP} state_t;

    state_t           state, state_nxt;
    logic [OUT_W-1:0] staging, staging_nxt;
    logic [PW-1:0]    per_cnt;
    logic [AW-1:0]    ack_cnt;
    logic             pend_force;
    logic             go;
    logic             tmo_hit;
    logic [IN_W-1:0]  in_nxt;

    assign go      = (per_cnt == PW'(REFRESH_DIV - 1)) || force_refresh || pend_force;
    assign tmo_hit = (state == REQ) && !refresh_ack && (ack_cnt == AW'(ACK_TMO - 1));

    // Word 2 takes the full 32-bit word and truncates to OUT_W, discarding the excess bits.
    always_comb begin
        staging_nxt = staging;
        if (wr_en) begin
            case (wr_idx)
                2'd0:    staging_nxt = OUT_W'({staging[OUT_W-1:32], wr_data});
                2'd1:    staging_nxt = OUT_W'({staging[OUT_W-1:64], wr_data, staging[31:0]});
                2'd2:    staging_nxt = OUT_W'({wr_data, staging[63:0]});
                default: staging_nxt = staging;
            endcase
        end
    end

`ifdef VBOARD_DEBOUNCE_EN
    logic [1:0] deb_cnt [IN_W];
    logic [1:0] deb_nxt [IN_W];

    always_comb begin
        in_nxt = in_vec;
        for (int unsigned i = 0; i < IN_W; i++) begin
            deb_nxt[i] = '0;
            if (in_vec_raw[i] != in_vec[i]) begin
                if (({1'b0, deb_cnt[i]} + 3'd1) >= 3'(DEB_CNT)) begin
                    in_nxt[i] = in_vec_raw[i];
                end else begin
                    deb_nxt[i] = deb_cnt[i] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < IN_W; i++) deb_cnt[i] <= '0;
        end else if (state == CAP) begin
            for (int unsigned i = 0; i < IN_W; i++) deb_cnt[i] <= deb_nxt[i];
        end
    end
`else
    always_comb begin
        in_nxt = in_vec_raw;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = REQ;
            REQ:     if (refresh_ack) state_nxt = CAP;
                     else if (tmo_hit) state_nxt = IDLE;
            CAP:     state_nxt = DROP;
            DROP:    if (!refresh_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        refresh_req = (state == REQ);
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            staging     <= '0;
            out_vec     <= '0;
            per_cnt     <= '0;
            ack_cnt     <= '0;
            pend_force  <= 1'b0;
            in_vec      <= '0;
            in_chg_mask <= '0;
            in_chg_irq  <= 1'b0;
            tmo_err     <= 1'b0;
        end else begin
            staging    <= staging_nxt;
            in_chg_irq <= 1'b0;
            if (state != IDLE && force_refresh) pend_force <= 1'b1;
            case (state)
                IDLE: begin
                    if (go) begin
                        out_vec    <= staging_nxt;
                        per_cnt    <= '0;
                        ack_cnt    <= '0;
                        pend_force <= 1'b0;
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                    end
                end
                REQ: begin
                    if (!refresh_ack && !tmo_hit) ack_cnt <= ack_cnt + 1'b1;
                end
                CAP: begin
                    in_vec      <= in_nxt;
                    in_chg_mask <= in_vec ^ in_nxt;
                    in_chg_irq  <= |(in_vec ^ in_nxt);
                end
                default: ;
            endcase
            if (tmo_hit)      tmo_err <= 1'b1;
            else if (err_clr) tmo_err <= 1'b0;
        end
    end

endmodule
